// File: rtl/icrc_engine_arbiter.sv
`timescale 1ns/1ps
// Packet-granular arbiter sharing one ICRC CRC32 engine between the RX and TX paths.
// Masks invariant header fields on each first beat and routes in-order engine results back to their owner.
module icrc_engine_arbiter #(
  parameter int DATA_BITS = 512,
  parameter int TAG_DEPTH = 4
) (
  input  logic                   nclk,
  input  logic                   nresetn,
  input  logic [DATA_BITS-1:0]   s_rx_tdata,
  input  logic [DATA_BITS/8-1:0] s_rx_tkeep,
  input  logic                   s_rx_tlast,
  input  logic                   s_rx_tvalid,
  output logic                   s_rx_tready,
  input  logic [DATA_BITS-1:0]   s_tx_tdata,
  input  logic [DATA_BITS/8-1:0] s_tx_tkeep,
  input  logic                   s_tx_tlast,
  input  logic                   s_tx_tvalid,
  output logic                   s_tx_tready,
  output logic [DATA_BITS-1:0]   m_crc_tdata,
  output logic [DATA_BITS/8-1:0] m_crc_tkeep,
  output logic                   m_crc_tlast,
  output logic                   m_crc_tvalid,
  input  logic                   m_crc_tready,
  output logic                   m_crc_tuser,
  input  logic [31:0]            s_res_crc,
  input  logic                   s_res_valid,
  output logic [31:0]            m_rx_res_crc,
  output logic                   m_rx_res_valid,
  output logic [31:0]            m_tx_res_crc,
  output logic                   m_tx_res_valid,
  output logic                   err_orphan
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Header fields that vary in flight are forced to ones before the engine sees them
  function automatic logic [DATA_BITS-1:0] build_mask();
    logic [DATA_BITS-1:0] m;
    m = '0;
    m[3:0]     = '1;
    m[11:8]    = '1;
    m[31:12]   = '1;
    m[63:56]   = '1;
    m[383:368] = '1;
    m[423:416] = '1;
    return m;
  endfunction

  localparam logic [DATA_BITS-1:0] HDR_MASK = build_mask();

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_RX = 2'd1,
    GNT_TX = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 last_tx_q, last_tx_d;
  logic                 first_q, first_d;
  logic [TAG_DEPTH-1:0] owner_q, owner_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 rx_res_vld_q, rx_res_vld_d;
  logic                 tx_res_vld_q, tx_res_vld_d;
  logic [31:0]          res_crc_q, res_crc_d;
  logic                 err_q, err_d;

  logic fifo_full, fifo_empty, beat_acc, push, pop;

  always_comb begin
    state_d      = state_q;
    last_tx_d    = last_tx_q;
    first_d      = first_q;
    owner_d      = owner_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    rx_res_vld_d = 1'b0;
    tx_res_vld_d = 1'b0;
    res_crc_d    = res_crc_q;
    err_d        = err_q;
    m_crc_tdata  = '0;
    m_crc_tkeep  = '0;
    m_crc_tlast  = 1'b0;
    m_crc_tvalid = 1'b0;
    m_crc_tuser  = 1'b0;
    s_rx_tready  = 1'b0;
    s_tx_tready  = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    fifo_full    = (cnt_q == CNT_W'(TAG_DEPTH));
    fifo_empty   = (cnt_q == '0);

    case (state_q)
      IDLE: begin
        if (!fifo_full && (s_rx_tvalid || s_tx_tvalid)) begin
          // RX wins a tie only when TX was served last
          if (s_rx_tvalid && (!s_tx_tvalid || last_tx_q)) state_d = GNT_RX;
          else                                             state_d = GNT_TX;
          first_d = 1'b1;
        end
      end
      GNT_RX: begin
        m_crc_tdata  = s_rx_tdata;
        m_crc_tkeep  = s_rx_tkeep;
        m_crc_tlast  = s_rx_tlast;
        m_crc_tvalid = s_rx_tvalid;
        s_rx_tready  = m_crc_tready;
      end
      GNT_TX: begin
        m_crc_tdata  = s_tx_tdata;
        m_crc_tkeep  = s_tx_tkeep;
        m_crc_tlast  = s_tx_tlast;
        m_crc_tvalid = s_tx_tvalid;
        m_crc_tuser  = 1'b1;
        s_tx_tready  = m_crc_tready;
      end
      default: state_d = IDLE;
    endcase

    if (first_q && (state_q != IDLE)) m_crc_tdata = m_crc_tdata | HDR_MASK;

    beat_acc = m_crc_tvalid && m_crc_tready;
    if (beat_acc) begin
      first_d = 1'b0;
      if (m_crc_tlast) begin
        state_d   = IDLE;
        last_tx_d = (state_q == GNT_TX);
        push      = 1'b1;
      end
    end

    pop = s_res_valid && !fifo_empty;
    if (s_res_valid && fifo_empty) err_d = 1'b1;

    if (push) begin
      owner_d[wr_ptr_q] = (state_q == GNT_TX);
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      res_crc_d = s_res_crc;
      if (owner_q[rd_ptr_q]) tx_res_vld_d = 1'b1;
      else                   rx_res_vld_d = 1'b1;
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge nclk or negedge nresetn) begin
    if (!nresetn) begin
      state_q      <= IDLE;
      last_tx_q    <= 1'b1;
      first_q      <= 1'b0;
      owner_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      rx_res_vld_q <= 1'b0;
      tx_res_vld_q <= 1'b0;
      res_crc_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_tx_q    <= last_tx_d;
      first_q      <= first_d;
      owner_q      <= owner_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      rx_res_vld_q <= rx_res_vld_d;
      tx_res_vld_q <= tx_res_vld_d;
      res_crc_q    <= res_crc_d;
      err_q        <= err_d;
    end
  end

  assign m_rx_res_crc   = res_crc_q;
  assign m_tx_res_crc   = res_crc_q;
  assign m_rx_res_valid = rx_res_vld_q;
  assign m_tx_res_valid = tx_res_vld_q;
  assign err_orphan     = err_q;

endmodule

// File: tb/tb_icrc_engine_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for icrc_engine_arbiter: random packet traffic against a
// packet-level model of arbitration order, header masking and result routing.
module tb_icrc_engine_arbiter;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int CW = 640;

  typedef struct packed {
    logic          last;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct packed {
    int          due;
    logic        owner;
    logic [31:0] crc;
  } res_t;

  logic          nclk = 1'b0;
  logic          nresetn;
  logic [DW-1:0] s_rx_tdata, s_tx_tdata, m_crc_tdata;
  logic [KW-1:0] s_rx_tkeep, s_tx_tkeep, m_crc_tkeep;
  logic          s_rx_tlast, s_rx_tvalid, s_rx_tready;
  logic          s_tx_tlast, s_tx_tvalid, s_tx_tready;
  logic          m_crc_tlast, m_crc_tvalid, m_crc_tready, m_crc_tuser;
  logic [31:0]   s_res_crc, m_rx_res_crc, m_tx_res_crc;
  logic          s_res_valid, m_rx_res_valid, m_tx_res_valid, err_orphan;

  icrc_engine_arbiter #(.DATA_BITS(DW), .TAG_DEPTH(4)) dut (
    .nclk(nclk), .nresetn(nresetn),
    .s_rx_tdata(s_rx_tdata), .s_rx_tkeep(s_rx_tkeep), .s_rx_tlast(s_rx_tlast),
    .s_rx_tvalid(s_rx_tvalid), .s_rx_tready(s_rx_tready),
    .s_tx_tdata(s_tx_tdata), .s_tx_tkeep(s_tx_tkeep), .s_tx_tlast(s_tx_tlast),
    .s_tx_tvalid(s_tx_tvalid), .s_tx_tready(s_tx_tready),
    .m_crc_tdata(m_crc_tdata), .m_crc_tkeep(m_crc_tkeep), .m_crc_tlast(m_crc_tlast),
    .m_crc_tvalid(m_crc_tvalid), .m_crc_tready(m_crc_tready), .m_crc_tuser(m_crc_tuser),
    .s_res_crc(s_res_crc), .s_res_valid(s_res_valid),
    .m_rx_res_crc(m_rx_res_crc), .m_rx_res_valid(m_rx_res_valid),
    .m_tx_res_crc(m_tx_res_crc), .m_tx_res_valid(m_tx_res_valid),
    .err_orphan(err_orphan)
  );

  always #5 nclk = ~nclk;

  // Stimulus queues (what each source still has to send) and scoreboard queues
  beat_t rx_src[$], tx_src[$], exp_rx[$], exp_tx[$];
  logic  exp_owner[$], res_owner[$];
  res_t  exp_res[$];

  int   tests = 0, fails = 0;
  int   cyc = 0, pending = 0;
  logic m_last_tx = 1'b1;
  logic m_err = 1'b0;
  logic hs_rx = 1'b0, hs_tx = 1'b0;
  logic in_pkt = 1'b0, cur_owner = 1'b0, bubble_chk = 1'b0, prev_stall = 1'b0;
  logic [CW-1:0] prev_word = '0;
  logic auto_res = 1'b0, man_req = 1'b0;
  logic [31:0] man_crc = '0;
  int   rdy_mode = 0;

  task automatic chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name, input int got, input int exp);
    tests++;
    fails++;
    $display("FAIL %s got=%0d exp=%0d", name, got, exp);
  endtask

  function automatic logic [DW-1:0] hdr_mask();
    logic [DW-1:0] m;
    m = '0;
    m[3:0]     = '1;
    m[31:8]    = '1;
    m[63:56]   = '1;
    m[383:368] = '1;
    m[423:416] = '1;
    return m;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic add_pkt(input logic tx, input int len, input logic zero);
    beat_t b, e;
    for (int i = 0; i < len; i++) begin
      b.data = zero ? '0 : rand_data();
      b.keep = zero ? '1 : {$urandom(), $urandom()};
      b.last = (i == len - 1);
      e = b;
      if (i == 0) e.data = e.data | hdr_mask();
      if (tx) begin tx_src.push_back(b); exp_tx.push_back(e); end
      else    begin rx_src.push_back(b); exp_rx.push_back(e); end
    end
  endtask

  // Packet order for nr RX and nt TX packets all queued together at an idle point:
  // strict alternation starting with whichever side was not served last.
  task automatic model_order(input int nr, input int nt);
    logic pick_tx;
    while (nr > 0 || nt > 0) begin
      if (nr == 0)      pick_tx = 1'b1;
      else if (nt == 0) pick_tx = 1'b0;
      else              pick_tx = !m_last_tx;
      exp_owner.push_back(pick_tx);
      m_last_tx = pick_tx;
      if (pick_tx) nt--; else nr--;
    end
  endtask

  task automatic issue(input logic [31:0] crc);
    res_t r;
    s_res_valid = 1'b1;
    s_res_crc   = crc;
    if (pending > 0) begin
      pending--;
      r.owner = res_owner.pop_front();
      r.crc   = crc;
      r.due   = cyc + 1;
      exp_res.push_back(r);
    end else begin
      m_err = 1'b1;
    end
  endtask

  // Driver: sources, engine ready and result pulses change 1 ns after each rising edge
  initial begin
    s_rx_tdata = '0; s_rx_tkeep = '0; s_rx_tlast = 1'b0; s_rx_tvalid = 1'b0;
    s_tx_tdata = '0; s_tx_tkeep = '0; s_tx_tlast = 1'b0; s_tx_tvalid = 1'b0;
    m_crc_tready = 1'b1; s_res_valid = 1'b0; s_res_crc = '0;
    forever begin
      @(posedge nclk);
      cyc++;
      #1;
      if (hs_rx && rx_src.size() > 0) void'(rx_src.pop_front());
      if (hs_tx && tx_src.size() > 0) void'(tx_src.pop_front());
      hs_rx = 1'b0;
      hs_tx = 1'b0;
      s_rx_tvalid = (rx_src.size() > 0);
      {s_rx_tlast, s_rx_tkeep, s_rx_tdata} = (rx_src.size() > 0) ? rx_src[0] : '0;
      s_tx_tvalid = (tx_src.size() > 0);
      {s_tx_tlast, s_tx_tkeep, s_tx_tdata} = (tx_src.size() > 0) ? tx_src[0] : '0;
      case (rdy_mode)
        1:       m_crc_tready = ~m_crc_tready;
        2:       m_crc_tready = ($urandom_range(0, 9) < 7);
        default: m_crc_tready = 1'b1;
      endcase
      s_res_valid = 1'b0;
      if (man_req) begin
        issue(man_crc);
        man_req = 1'b0;
      end else if (auto_res && pending > 0 && $urandom_range(0, 3) == 0) begin
        issue($urandom());
      end
    end
  end

  // Monitor: samples on the falling edge, pops expectations when the DUT presents output
  initial begin
    beat_t e;
    res_t  r;
    forever begin
      @(negedge nclk);
      if (!nresetn) begin
        in_pkt = 1'b0; prev_stall = 1'b0; bubble_chk = 1'b0;
        hs_rx = 1'b0; hs_tx = 1'b0;
        continue;
      end
      hs_rx = s_rx_tvalid && s_rx_tready;
      hs_tx = s_tx_tvalid && s_tx_tready;
      if (bubble_chk) begin
        chk("bubble_after_tlast", m_crc_tvalid, 1'b0);
        bubble_chk = 1'b0;
      end
      if (prev_stall)
        chk("stall_hold", {m_crc_tvalid, m_crc_tuser, m_crc_tlast, m_crc_tkeep, m_crc_tdata}, prev_word);
      prev_stall = m_crc_tvalid && !m_crc_tready;
      prev_word  = {m_crc_tvalid, m_crc_tuser, m_crc_tlast, m_crc_tkeep, m_crc_tdata};
      if (m_crc_tvalid && m_crc_tready) begin
        if (!in_pkt) begin
          if (exp_owner.size() == 0) begin
            fail_now("unexpected_packet_owner", int'(m_crc_tuser), -1);
            cur_owner = m_crc_tuser;
          end else begin
            cur_owner = exp_owner.pop_front();
            chk("packet_owner", m_crc_tuser, cur_owner);
          end
          in_pkt = 1'b1;
        end
        if ((cur_owner && exp_tx.size() == 0) || (!cur_owner && exp_rx.size() == 0)) begin
          fail_now("unexpected_beat", int'(cur_owner), -1);
        end else begin
          e = cur_owner ? exp_tx.pop_front() : exp_rx.pop_front();
          chk(cur_owner ? "beat_tx" : "beat_rx", {m_crc_tlast, m_crc_tkeep, m_crc_tdata}, e);
          chk("beat_tuser", m_crc_tuser, cur_owner);
        end
        if (m_crc_tlast) begin
          in_pkt = 1'b0;
          bubble_chk = 1'b1;
          res_owner.push_back(cur_owner);
          pending++;
        end
      end
      if (exp_res.size() > 0 && exp_res[0].due == cyc) begin
        r = exp_res.pop_front();
        if (r.owner) begin
          chk("res_tx_valid", {m_tx_res_valid, m_rx_res_valid}, 2'b10);
          chk("res_tx_crc", m_tx_res_crc, r.crc);
        end else begin
          chk("res_rx_valid", {m_tx_res_valid, m_rx_res_valid}, 2'b01);
          chk("res_rx_crc", m_rx_res_crc, r.crc);
        end
      end else if (m_rx_res_valid || m_tx_res_valid) begin
        fail_now("unexpected_result_pulse", int'({m_tx_res_valid, m_rx_res_valid}), 0);
      end
    end
  end

  task automatic wait_done(input int bound, input string name);
    int n = 0;
    while (!(rx_src.size() == 0 && tx_src.size() == 0 && exp_rx.size() == 0 &&
             exp_tx.size() == 0 && exp_owner.size() == 0 && pending == 0 &&
             exp_res.size() == 0 && !in_pkt)) begin
      @(negedge nclk);
      n++;
      if (n > bound) begin
        fail_now({"timeout_", name}, n, bound);
        return;
      end
    end
    repeat (2) @(negedge nclk);
  endtask

  task automatic wait_man();
    int n = 0;
    while (man_req) begin
      @(negedge nclk);
      n++;
      if (n > 20) begin
        fail_now("timeout_manual_result", n, 20);
        man_req = 1'b0;
        return;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_tready"}, s_rx_tready, 1'b0);
    chk({tag, "_tx_tready"}, s_tx_tready, 1'b0);
    chk({tag, "_crc_tvalid"}, m_crc_tvalid, 1'b0);
    chk({tag, "_crc_tuser"}, m_crc_tuser, 1'b0);
    chk({tag, "_res_valids"}, {m_rx_res_valid, m_tx_res_valid}, 2'b00);
    chk({tag, "_res_crcs"}, {m_rx_res_crc, m_tx_res_crc}, 64'd0);
    chk({tag, "_err_orphan"}, err_orphan, 1'b0);
  endtask

  initial begin
    int nr, nt, n, nvalid;
    nresetn = 1'b0;
    repeat (3) @(posedge nclk);
    #3 check_reset_outputs("reset");
    @(posedge nclk);
    #3 nresetn = 1'b1;

    // Tie straight after reset: RX first, then strict alternation
    auto_res = 1'b1;
    rdy_mode = 0;
    add_pkt(1'b0, 2, 1'b0);
    add_pkt(1'b1, 3, 1'b0);
    add_pkt(1'b0, 1, 1'b0);
    add_pkt(1'b1, 2, 1'b0);
    model_order(2, 2);
    wait_done(400, "tie");

    // All-zero RX packet exposes the header mask on beat 0 only
    add_pkt(1'b0, 3, 1'b1);
    model_order(1, 0);
    wait_done(200, "zero_rx");

    // TX packet under alternating engine backpressure
    rdy_mode = 1;
    add_pkt(1'b1, 4, 1'b0);
    model_order(0, 1);
    wait_done(200, "tx_toggle");
    rdy_mode = 0;

    // Owner FIFO full: a fifth packet must wait for a result
    auto_res = 1'b0;
    add_pkt(1'b0, 2, 1'b0);
    add_pkt(1'b1, 1, 1'b0);
    add_pkt(1'b0, 3, 1'b0);
    add_pkt(1'b1, 2, 1'b0);
    model_order(2, 2);
    n = 0;
    while (pending < 4 && n < 200) begin
      @(negedge nclk);
      n++;
    end
    chk("four_packets_done", pending, 4);
    add_pkt(1'b0, 2, 1'b0);
    model_order(1, 0);
    nvalid = 0;
    repeat (30) begin
      @(negedge nclk);
      if (m_crc_tvalid || s_rx_tready) nvalid++;
    end
    chk("full_fifo_blocks_grant", nvalid, 0);
    man_crc = 32'hDEADBEEF;
    man_req = 1'b1;
    wait_man();
    auto_res = 1'b1;
    wait_done(400, "fifo_full");

    // Orphan result: no pulse, sticky error
    man_crc = $urandom();
    man_req = 1'b1;
    wait_man();
    repeat (3) @(negedge nclk);
    chk("err_orphan_set", err_orphan, m_err);

    // Randomised traffic with random backpressure and result timing
    rdy_mode = 2;
    for (int round = 0; round < 3; round++) begin
      nr = $urandom_range(0, 8);
      nt = $urandom_range(1, 8);
      for (int i = 0; i < nr; i++) add_pkt(1'b0, $urandom_range(1, 6), 1'b0);
      for (int i = 0; i < nt; i++) add_pkt(1'b1, $urandom_range(1, 6), 1'b0);
      model_order(nr, nt);
      wait_done(3000, "random");
    end
    chk("err_orphan_held", err_orphan, m_err);

    // Reset in the middle of a 5-beat packet
    rdy_mode = 0;
    add_pkt(1'b0, 5, 1'b0);
    model_order(1, 0);
    n = 0;
    while (rx_src.size() != 3 && n < 50) begin
      @(posedge nclk);
      #2;
      n++;
    end
    chk("mid_packet_reached", rx_src.size(), 3);
    nresetn = 1'b0;
    #1 check_reset_outputs("midreset");
    rx_src.delete(); tx_src.delete(); exp_rx.delete(); exp_tx.delete();
    exp_owner.delete(); res_owner.delete(); exp_res.delete();
    pending = 0;
    m_err = 1'b0;
    m_last_tx = 1'b1;
    repeat (2) @(posedge nclk);
    #3 nresetn = 1'b1;
    add_pkt(1'b1, 2, 1'b0);
    add_pkt(1'b0, 2, 1'b0);
    model_order(1, 1);
    wait_done(400, "after_reset");
    chk("err_orphan_after_reset", err_orphan, m_err);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icrc_engine_arbiter.md
ICRC_ENGINE_ARBITER -- requirements
Module: icrc_engine_arbiter

Interface
REQ-001 SHALL have parameters: DATA_BITS, 512, stream data width; TAG_DEPTH, 4, owner-FIFO depth (power of 2).
REQ-002 SHALL have ports, one per line (name  direction  width  meaning):
  nclk  in  1  clock; all logic on rising edge
  nresetn  in  1  reset; asynchronous, active-low
  s_rx_tdata/tkeep/tlast  in  512/64/1  RX-path packet stream
  s_rx_tvalid  in  1  RX beat valid
  s_rx_tready  out  1  RX beat accepted
  s_tx_tdata/tkeep/tlast/tvalid  in  512/64/1/1  TX-path packet stream
  s_tx_tready  out  1  TX beat accepted
  m_crc_tdata/tkeep/tlast  out  512/64/1  masked stream to CRC32 engine
  m_crc_tvalid  out  1  engine beat valid
  m_crc_tready  in  1  engine ready
  m_crc_tuser  out  1  owner of current beat (0=RX, 1=TX)
  s_res_crc  in  32  engine ICRC result
  s_res_valid  in  1  result pulse, one per packet, in packet order
  m_rx_res_crc/m_rx_res_valid  out  32/1  result routed to RX path
  m_tx_res_crc/m_tx_res_valid  out  32/1  result routed to TX path
  err_orphan  out  1  sticky: result arrived with no owner pending

Function
REQ-003 SHALL share one CRC engine between RX and TX at packet granularity; grant held from first beat to accepted tlast beat.
REQ-004 FSM states IDLE, GNT_RX, GNT_TX; reset state IDLE.
REQ-005 IDLE: if owner FIFO not full and any s_*_tvalid, move next edge to GNT of chosen source; else stay.
REQ-006 Choice: only one valid -> that one; both valid -> source not served last (round-robin); last_served resets to TX so RX wins first tie.
REQ-007 GNT_x: m_crc_* = granted source's tdata/tkeep/tlast/tvalid, combinational; granted tready = m_crc_tready; non-granted tready = 0; IDLE: both treadys 0, m_crc_tvalid 0.
REQ-008 Beat accepted when m_crc_tvalid & m_crc_tready; on accepted tlast return to IDLE next edge, update last_served, push owner ID to FIFO; one bubble cycle between packets.
REQ-009 First-beat flag set on grant entry, cleared after first accepted beat; single-beat packet is both first and last.
REQ-010 First beat only: m_crc_tdata[423:0] = src[423:0] OR mask, mask bits set at [3:0], [11:8], [31:12], [63:56], [383:368], [423:416], all others 0; bits [511:424] and all later beats pass unmodified.
REQ-011 m_crc_tuser = 0 in GNT_RX, 1 in GNT_TX, 0 in IDLE.
REQ-012 m_crc_* stable while tvalid & !tready (follows source AXI4S stability).
REQ-013 Owner FIFO TAG_DEPTH x 1 bit; push per REQ-008, pop on s_res_valid when not empty; simultaneous push/pop leaves count unchanged; overflow impossible per REQ-005.
REQ-014 On s_res_valid with FIFO non-empty: next cycle, m_rx_res_valid or m_tx_res_valid (per popped owner) pulses 1 cycle with registered s_res_crc; other valid stays 0.
REQ-015 On s_res_valid with FIFO empty: no result output, err_orphan set, held until reset.
REQ-016 No backpressure on results; result outputs are single-cycle pulses.

Reset
REQ-017 nresetn low asynchronously forces: FSM IDLE, FIFO empty, last_served TX, first flag 0, all tready/tvalid/res_valid 0, res_crc 0, err_orphan 0.
REQ-018 Reset mid-packet abandons packet; no result generated for it; after release first packet starts in IDLE with mask applied.

Verification
REQ-019 Single RX 3-beat packet, tdata all 0, tready=1 -> beat0 low bits show mask (bits [31:8], [3:0], [63:56], [383:368], [423:416] = 1), beats 1-2 zero, tuser 0.
REQ-020 RX and TX both valid at IDLE after reset -> RX packet first, then TX after one bubble; repeat tie -> RX again only after TX served.
REQ-021 m_crc_tready toggles 1/0 during 4-beat TX packet -> no beat lost/duplicated, data stable while stalled, tlast returns FSM to IDLE.
REQ-022 Four packets sent (RX,TX,RX,TX), no results -> fifth packet not granted until s_res_valid with crc 0xDEADBEEF -> m_rx_res_valid pulses with 0xDEADBEEF, grant resumes.
REQ-023 s_res_valid with FIFO empty -> no output pulse, err_orphan=1 until nresetn low.
REQ-024 Assert nresetn low on beat 2 of 5-beat packet -> all outputs 0 immediately; after release a new packet gets mask on its first beat.
